// File: rtl/fnd_bcd_scanner_pkg.sv
// fnd_bcd_scanner_pkg: shared FSM encoding, scan default and 7-segment table
package fnd_bcd_scanner_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SCAN_DIV_DEFAULT = 100000;
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/fnd_bcd_scanner_bcd_to_seg.sv
// bcd_to_seg: maps one BCD digit plus blank flag to active-low segments
module bcd_to_seg
  import fnd_bcd_scanner_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);
  // non-decimal codes fall back to blank so the display never shows garbage
  always_comb seg = (blank || digit > 4'd9) ? BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/fnd_bcd_scanner.sv
// fnd_bcd_scanner: double-dabble BCD conversion of sum, multiplexed onto 4 digits
module fnd_bcd_scanner
  import fnd_bcd_scanner_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] sum,
  output logic [3:0] seg_comm,
  output logic [7:0] seg,
  output logic       busy
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  state_t          state;
  logic            valid;
  logic [8:0]      last_sum;
  logic [8:0]      bin;
  logic [11:0]     bcd;
  logic [11:0]     adj;
  logic [3:0]      cnt;
  logic [3:0]      ones, tens, hund;
  logic [CW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic [3:0]      dig;
  logic            blank;
  logic [7:0]      seg_nxt;
  // add-3 correction on every nibble that would overflow past 9 after shifting
  always_comb begin
    adj[3:0]  = bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0];
    adj[7:4]  = bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4];
    adj[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
  end
  // conversion FSM: capture on change, 9 shifts, then publish all digits at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      last_sum <= '0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ones     <= '0;
      tens     <= '0;
      hund     <= '0;
    end else begin
      case (state)
        IDLE: if (!valid || sum != last_sum) begin
          last_sum <= sum;
          bin      <= sum;
          bcd      <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd8) state <= DONE;
        end
        DONE: begin
          ones  <= bcd[3:0];
          tens  <= bcd[7:4];
          hund  <= bcd[11:8];
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // scan timer: advance the active digit once per SCAN_DIV cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_cnt == SCAN_LAST ? '0 : scan_cnt + 1'b1;
      if (scan_cnt == SCAN_LAST) idx <= idx + 2'd1;
    end
  end
  // select the active digit and apply leading-zero blanking; digit 3 is always dark
  always_comb begin
    dig   = idx == 2'd0 ? ones : idx == 2'd1 ? tens : hund;
    blank = idx == 2'd3 || (idx == 2'd2 && hund == 4'd0) ||
            (idx == 2'd1 && hund == 4'd0 && tens == 4'd0);
  end
  bcd_to_seg u_bcd_to_seg (
    .digit(dig),
    .blank(blank),
    .seg  (seg_nxt)
  );
  // registered drive keeps digit enable and segment pattern switching together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_comm <= 4'b1111;
      seg      <= BLANK;
    end else begin
      seg_comm <= ~(4'b0001 << idx);
      seg      <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// tb_fnd_bcd_scanner: random and directed checks against a decimal-arithmetic model
module tb_fnd_bcd_scanner;
  localparam int SD = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] sum = '0;
  logic [3:0] seg_comm;
  logic [7:0] seg;
  logic       busy;
  int errors = 0;
  int checks = 0;
  logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] ec [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] es [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
  int k = 0, t = 0, mlast = 0, mcap = 0, mdisp = 0;
  bit mvalid = 0, have = 0;
  logic [3:0] e_comm;
  logic [7:0] e_seg;
  logic       e_busy;

  fnd_bcd_scanner #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .sum(sum),
    .seg_comm(seg_comm), .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int v, input int p);
    int h, tn, o;
    h = v / 100;
    tn = (v / 10) % 10;
    o = v % 10;
    if (p == 0) return tab[o];
    if (p == 1) return (h == 0 && tn == 0) ? 8'hFF : tab[tn];
    if (p == 2) return h == 0 ? 8'hFF : tab[h];
    return 8'hFF;
  endfunction

  // model: a conversion takes 11 edges from capture to display; scan position from edge count
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; t = 0; mvalid = 0; mlast = 0; mdisp = 0; have = 0;
    end else begin
      e_comm = ~(4'b0001 << ((k / SD) % 4));
      e_seg  = enc(mdisp, (k / SD) % 4);
      if (t == 0) begin
        if (!mvalid || int'(sum) != mlast) begin
          mcap = int'(sum); mlast = int'(sum); t = 1;
        end
      end else if (t == 10) begin
        mdisp = mcap; mvalid = 1; t = 0;
      end else t++;
      e_busy = t != 0;
      k++;
      have = 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_comm", 12'(seg_comm), 12'hF);
      chk("rst_seg", 12'(seg), 12'hFF);
      chk("rst_busy", 12'(busy), 12'h0);
    end else if (have) begin
      chk("comm", 12'(seg_comm), 12'(e_comm));
      chk("seg", 12'(seg), 12'(e_seg));
      chk("busy", 12'(busy), 12'(e_busy));
    end
  end

  task automatic settle;
    int lows = 0;
    for (int n = 0; n < 80 && lows < 2; n++) begin
      @(negedge clk);
      lows = busy ? 0 : lows + 1;
    end
    chk("settle", 12'(lows), 12'd2);
  endtask

  task automatic wait_busy;
    int w = 0;
    while (!busy && w < 6) begin @(negedge clk); w++; end
    chk("busy_rise", 12'(busy), 12'h1);
  endtask

  task automatic show(input string nm, input logic [7:0] e0, e1, e2, e3);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      case (seg_comm)
        4'b1110: chk(nm, 12'(seg), 12'(e0));
        4'b1101: chk(nm, 12'(seg), 12'(e1));
        4'b1011: chk(nm, 12'(seg), 12'(e2));
        4'b0111: chk(nm, 12'(seg), 12'(e3));
        default: chk({nm, "_comm"}, 12'(seg_comm), 12'b1110);
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int v;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      chk("scan_comm", 12'(seg_comm), 12'(ec[n / 4]));
      chk("scan_seg", 12'(seg), 12'(es[n / 4]));
    end
    settle();
    sum = 9'd511;
    wait_busy();
    bc = 0;
    while (busy && bc < 30) begin @(negedge clk); bc++; end
    chk("busy_len", 12'(bc), 12'd10);
    settle();
    show("d511", 8'hF9, 8'hF9, 8'h92, 8'hFF);
    sum = 9'd7;
    settle();
    show("d7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    sum = 9'd200;
    settle();
    show("d200", 8'hC0, 8'hC0, 8'hA4, 8'hFF);
    sum = 9'd255;
    settle();
    sum = 9'd254;
    wait_busy();
    repeat (3) @(negedge clk);
    sum = 9'd100;
    settle();
    show("d100", 8'hC0, 8'hC0, 8'hF9, 8'hFF);
    sum = 9'd321;
    wait_busy();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_comm", 12'(seg_comm), 12'hF);
    chk("arst_seg", 12'(seg), 12'hFF);
    chk("arst_busy", 12'(busy), 12'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (11) @(negedge clk);
    chk("arst_pre", 12'(seg), 12'hFF);
    @(negedge clk);
    chk("arst_show", 12'(seg), 12'hB0);
    chk("arst_idx", 12'(seg_comm), 12'b1011);
    repeat (60) begin
      sum = 9'($urandom_range(0, 511));
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    repeat (6) begin
      v = int'($urandom_range(0, 511));
      sum = 9'(v);
      settle();
      show("rand", enc(v, 0), enc(v, 1), enc(v, 2), enc(v, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
